// File: rtl/multiword_addsub_seq.sv
// rtl/multiword_addsub_seq.sv - word-serial N-bit adder-subtractor built on one M-bit carry-skip slice

// M-bit carry-skip adder-subtractor slice: ripple inside each R-bit block, skip across blocks
module cs_addsub_slice #(
  parameter int M = 32,
  parameter int R = 4
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [M-1:0] s,
  output logic         cout,
  output logic         v
);

  logic [M-1:0] bb;
  logic         c;      // carry entering the current block
  logic         cr;     // ripple carry inside the current block
  logic         bp;     // block propagate: every bit of the block propagates
  logic         p;
  logic         c_msb;  // carry into bit M-1, needed for signed overflow

  // ripple each block, then let the block carry-out bypass the ripple when the block fully propagates
  always_comb begin
    bb    = b ^ {M{sub}};
    c     = cin ^ sub;
    cr    = 1'b0;
    bp    = 1'b1;
    p     = 1'b0;
    c_msb = 1'b0;
    s     = '0;
    for (int blk = 0; blk < M / R; blk++) begin
      bp = 1'b1;
      cr = c;
      for (int j = 0; j < R; j++) begin
        p = a[blk*R+j] ^ bb[blk*R+j];
        bp = bp & p;
        s[blk*R+j] = p ^ cr;
        if (blk*R+j == M-1) c_msb = cr;
        cr = (a[blk*R+j] & bb[blk*R+j]) | (p & cr);
      end
      c = bp ? c : cr;
    end
    cout = c;
    v    = c_msb ^ c;
  end

endmodule

// Sequential multiword adder-subtractor: one M-bit word per cycle, LSB word first
module multiword_addsub_seq #(
  parameter int M = 32,
  parameter int R = 4,
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [M*W-1:0]   x,
  input  logic [M*W-1:0]   y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M*W-1:0]   out,
  output logic             cout,
  output logic             v
);

  localparam int N  = M * W;
  localparam int KW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [KW-1:0]   k;
  logic            carry;
  logic [N-1:0]    x_reg;
  logic [N-1:0]    y_reg;   // already inverted for subtraction
  logic [M-1:0]    slice_s;
  logic            slice_cout;
  logic            slice_v;
  logic            last_word;

  assign last_word = (k == KW'(W - 1));

  // the +1 of two's-complement negation enters through the carry register, so the slice only adds
  cs_addsub_slice #(.M(M), .R(R)) u_slice (
    .a    (x_reg[k*M +: M]),
    .b    (y_reg[k*M +: M]),
    .cin  (carry),
    .sub  (1'b0),
    .s    (slice_s),
    .cout (slice_cout),
    .v    (slice_v)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_word) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // operand capture, word-serial accumulation and flag capture
  always_ff @(posedge clk) begin
    if (rst) begin
      k     <= '0;
      carry <= 1'b0;
      x_reg <= '0;
      y_reg <= '0;
      out   <= '0;
      cout  <= 1'b0;
      v     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg <= x;
            y_reg <= y ^ {N{sub}};
            carry <= sub;
            k     <= '0;
          end
        end
        RUN: begin
          out[k*M +: M] <= slice_s;
          carry         <= slice_cout;
          if (last_word) begin
            cout <= slice_cout;
            v    <= slice_v;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_addsub_seq.sv
// tb/tb_multiword_addsub_seq.sv - directed self-checking bench for multiword_addsub_seq

module tb_multiword_addsub_seq;

  localparam int M = 32;
  localparam int R = 4;
  localparam int W = 4;
  localparam int N = M * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         sub;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic         cout;
  logic         v;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [N-1:0] ALL1  = {N{1'b1}};
  localparam logic [N-1:0] ONE   = 128'd1;
  localparam logic [N-1:0] SMAX  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SMIN  = {1'b1, {(N-1){1'b0}}};

  multiword_addsub_seq #(.M(M), .R(R), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .cout      (cout),
    .v         (v)
  );

  always #5 clk = ~clk;

  // present one request, wait for out_valid (bounded), capture outputs, then release the result
  task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] ya, input logic s,
                        output logic [N-1:0] o, output logic co, output logic vo,
                        output int lat, output bit timeout);
    @(negedge clk);
    in_valid = 1'b1; x = xa; y = ya; sub = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0; x = '0; y = '0; sub = 1'b0;
    lat = 0;
    timeout = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) timeout = 1'b1;
    o = out; co = cout; vo = v;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out !== '0) begin n_fail++; $display("FAIL reset_out got %h want 0", out); end
    n_checks++; if ({cout, v} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b%b want 00", cout, v); end
  endtask

  task automatic test_add_wrap();
    logic [N-1:0] o; logic co, vo; int lat; bit to;
    run_op(ALL1, ONE, 1'b0, o, co, vo, lat, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL add_wrap_timeout got no out_valid want out_valid"); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL add_wrap_latency got %0d want 4", lat); end
    n_checks++; if (o !== '0) begin n_fail++; $display("FAIL add_wrap_out got %h want 0", o); end
    n_checks++; if ({co, vo} !== 2'b10) begin n_fail++; $display("FAIL add_wrap_flags got cout=%b v=%b want cout=1 v=0", co, vo); end
  endtask

  task automatic test_sub_borrow();
    logic [N-1:0] o; logic co, vo; int lat; bit to;
    run_op('0, ONE, 1'b1, o, co, vo, lat, to);
    n_checks++; if (to || o !== ALL1) begin n_fail++; $display("FAIL sub_borrow_out got %h want %h", o, ALL1); end
    n_checks++; if ({co, vo} !== 2'b00) begin n_fail++; $display("FAIL sub_borrow_flags got cout=%b v=%b want cout=0 v=0", co, vo); end
  endtask

  task automatic test_overflow();
    logic [N-1:0] o; logic co, vo; int lat; bit to;
    run_op(SMAX, ONE, 1'b0, o, co, vo, lat, to);
    n_checks++; if (to || o !== SMIN) begin n_fail++; $display("FAIL add_ovf_out got %h want %h", o, SMIN); end
    n_checks++; if ({co, vo} !== 2'b01) begin n_fail++; $display("FAIL add_ovf_flags got cout=%b v=%b want cout=0 v=1", co, vo); end
    run_op(SMIN, ONE, 1'b1, o, co, vo, lat, to);
    n_checks++; if (to || o !== SMAX) begin n_fail++; $display("FAIL sub_ovf_out got %h want %h", o, SMAX); end
    n_checks++; if ({co, vo} !== 2'b11) begin n_fail++; $display("FAIL sub_ovf_flags got cout=%b v=%b want cout=1 v=1", co, vo); end
  endtask

  task automatic test_word_carry();
    logic [N-1:0] o; logic co, vo; int lat; bit to;
    run_op(128'h00000000_00000000_00000000_FFFFFFFF, ONE, 1'b0, o, co, vo, lat, to);
    n_checks++; if (to || o !== 128'h00000000_00000000_00000001_00000000) begin
      n_fail++; $display("FAIL word_carry_out got %h want 00000000000000000000000100000000", o); end
    n_checks++; if ({co, vo} !== 2'b00) begin n_fail++; $display("FAIL word_carry_flags got cout=%b v=%b want 0 0", co, vo); end
    run_op(128'h12345678_9ABCDEF0_0F0F0F0F_80000000, 128'h11111111_11111111_F0F0F0F1_80000000, 1'b0, o, co, vo, lat, to);
    n_checks++; if (to || o !== 128'h23456789_ABCDF002_00000001_00000000) begin
      n_fail++; $display("FAIL mixed_add_out got %h want 23456789abcdf0020000000100000000", o); end
  endtask

  task automatic test_hold();
    int lat; bit seen;
    @(negedge clk);
    in_valid = 1'b1; x = 128'd5; y = 128'd3; sub = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++; if (!out_valid) begin n_fail++; $display("FAIL hold_timeout got no out_valid want out_valid"); end
    @(negedge clk);
    in_valid = 1'b1; x = 128'd100; y = 128'd1; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++; if (out !== 128'd8 || {cout, v} !== 2'b00) begin
        n_fail++; $display("FAIL hold_result cycle %0d got %h c=%b v=%b want 8 c=0 v=0", i, out, cout, v); end
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL hold_handshake cycle %0d got in_ready=%b out_valid=%b want 0 1", i, in_ready, out_valid); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL hold_return got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    @(posedge clk);
    #1;
    in_valid = 1'b0; x = '0; y = '0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
    n_checks++; if (!seen || lat !== 4) begin n_fail++; $display("FAIL hold_second_latency got %0d want 4", lat); end
    n_checks++; if (out !== 128'd101) begin n_fail++; $display("FAIL hold_second_out got %h want 65", out); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [N-1:0] o; logic co, vo; int lat; bit to;
    @(negedge clk);
    in_valid = 1'b1; x = ALL1; y = ONE; sub = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_handshake got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    n_checks++; if (out !== '0) begin n_fail++; $display("FAIL midrst_out got %h want 0", out); end
    run_op(128'd10, 128'd3, 1'b1, o, co, vo, lat, to);
    n_checks++; if (to || o !== 128'd7) begin n_fail++; $display("FAIL midrst_next_out got %h want 7", o); end
    n_checks++; if ({co, vo} !== 2'b10) begin n_fail++; $display("FAIL midrst_next_flags got cout=%b v=%b want 1 0", co, vo); end
  endtask

  initial begin
    test_reset();
    test_add_wrap();
    test_sub_borrow();
    test_overflow();
    test_word_carry();
    test_hold();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiword_addsub_seq.md
MULTIWORD_ADDSUB_SEQ -- requirements
Module: multiword_addsub_seq

Interface
REQ-001 Parameter M, default 32, slice width in bits processed per cycle by the carry-skip adder-subtractor.
REQ-002 Parameter R, default 4, carry-skip block size passed to the slice adder; M SHALL be divisible by R and M > R.
REQ-003 Parameter W, default 4, number of M-bit words per operand; W >= 1; N = M*W is the full operand width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 in_valid  input  1  request carries valid operands.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 sub  input  1  0 = x + y, 1 = x - y; sampled on accept.
REQ-009 x  input  N  first operand, two's complement; sampled on accept.
REQ-010 y  input  N  second operand, two's complement; sampled on accept.
REQ-011 out_valid  output  1  result outputs valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out  output  N  result, registered.
REQ-014 cout  output  1  carry out of the MSB of the N-bit operation (for sub: 1 = no borrow).
REQ-015 v  output  1  signed overflow of the N-bit operation.

Function
REQ-016 Block SHALL contain one M-bit combinational carry-skip adder-subtractor slice, used with its sub input tied to 0; y inversion for subtraction is done in this block.
REQ-017 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-018 IDLE: in_ready = 1, out_valid = 0; in_valid = 1 -> latch x, y XOR {N{sub}}, sub; word index k = 0; carry register = sub; go to RUN.
REQ-019 RUN: in_ready = 0, out_valid = 0; each cycle slice adds x word k, inverted-or-not y word k, carry register; sum written to out word k; carry register <= slice cout; k <= k + 1.
REQ-020 RUN on k = W-1: cout <= slice cout, v <= slice v, go to DONE; W = 1 gives exactly one RUN cycle.
REQ-021 Latency: accept at edge T -> out_valid = 1 after edge T+W; no combinational path from inputs to outputs.
REQ-022 DONE: out_valid = 1, in_ready = 0; out, cout, v held stable while out_ready = 0.
REQ-023 DONE with out_ready = 1 -> IDLE next edge; next accept earliest one cycle later (one request in flight, throughput 1 per W+2 cycles).
REQ-024 in_valid and input changes while not in IDLE SHALL be ignored; latched operands never change mid-operation.
REQ-025 Arithmetic: result = (x + (sub ? ~y + 1 : y)) mod 2^N; cout and v identical to a single N-bit adder-subtractor on the same operands.
REQ-026 Words of out not yet written in RUN SHALL retain the previous value; out is valid only when out_valid = 1.
REQ-027 k counter width ceil(log2(W)) (min 1); no wrap beyond W-1 is reachable.

Reset
REQ-028 rst = 1 at an edge -> state IDLE, in_ready = 1, out_valid = 0, out = 0, cout = 0, v = 0, k = 0, carry register = 0, operand registers = 0.
REQ-029 rst takes priority over any handshake in the same cycle; reset in RUN or DONE aborts the operation and discards its result.

Verification (M=32, R=4, W=4, N=128)
REQ-030 add x = all-ones, y = 1 -> out = 0, cout = 1, v = 0; out_valid high exactly 4 cycles after accept.
REQ-031 sub x = 0, y = 1 -> out = all-ones, cout = 0, v = 0.
REQ-032 add x = 0x7FFF...FFFF, y = 1 -> out = 0x8000...0000, cout = 0, v = 1; sub x = 0x8000...0000, y = 1 -> out = 0x7FFF...FFFF, v = 1, cout = 1.
REQ-033 add x = 0x00000000_00000000_00000000_FFFFFFFF, y = 1 -> out = 0x00000000_00000000_00000001_00000000 (carry crosses word boundary), v = 0, cout = 0.
REQ-034 hold out_ready = 0 for 3 cycles in DONE while driving new in_valid = 1 with different operands -> out/cout/v unchanged, in_ready = 0, new request not taken until after the IDLE return.
REQ-035 assert rst for one cycle in RUN at k = 2 -> next cycle in_ready = 1, out_valid = 0, out = 0; a following request completes with correct result.
